hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Issue-side (ID stage) counterpart of the EX-stage forwarding logic.
- Records every register write at issue, before it is forwardable, and retires it at writeback.
- Stalls ID when a source register's producer has not yet reached a forwardable stage (load-use), or when a register's in-flight write count would overflow.
- Sits between decode and the ID/EX pipeline register; its stall drives PC/IF-ID hold and ID/EX bubble insertion.

Parameters:
- NREG, 32, number of architectural registers; register 0 is never tracked.
- LOAD_LAT, 1, cycles after issue before a load result becomes forwardable.
- CNT_W, 2, width of the per-register outstanding-write counter; maximum in flight is 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  ID holds a valid instruction this cycle
- issue_regwrite  in  1  the ID instruction writes a register
- issue_is_load  in  1  the ID instruction is a load
- issue_dest  in  5  destination register of the ID instruction
- rs_id  in  5  source A of the ID instruction
- rt_id  in  5  source B of the ID instruction
- flush  in  1  squash the ID instruction this cycle (branch taken)
- regwrite_wb  in  1  WB stage writes the register file this cycle
- dest_wb  in  5  WB destination register
- stall  out  1  hold IF/ID, bubble into ID/EX (combinational)
- busy  out  1  at least one register has an outstanding write (registered)
- sb_err  out  1  sticky: a retirement was seen for an untracked register

Behaviour:
- State per register r=1..NREG-1:
  - out_cnt[r] (CNT_W bits): number of outstanding writes.
  - rdy_cnt[r] (2 bits): cycles until the youngest write becomes forwardable.
- Reset (rst=1, asynchronous): all out_cnt=0, all rdy_cnt=0, busy=0, sb_err=0. stall=0 while rst is high.
- src_hit(x): x!=0 and out_cnt[x]!=0 and rdy_cnt[x]!=0.
- stall = issue_valid & ~flush & (src_hit(rs_id) | src_hit(rt_id) | (issue_regwrite & issue_dest!=0 & out_cnt[issue_dest]==max)).
- accept = issue_valid & ~flush & ~stall & issue_regwrite & issue_dest!=0.
- On accept, for d=issue_dest: out_cnt[d]+1; rdy_cnt[d] <= issue_is_load ? LOAD_LAT : 0.
- Every cycle, each nonzero rdy_cnt not being reloaded decrements by 1.
- Retire = regwrite_wb & dest_wb!=0: out_cnt[dest_wb]-1.
  - If out_cnt is already 0: no change, and sb_err is set (sticky until rst).
- Accept and retire to the same register in the same cycle: net out_cnt unchanged; rdy_cnt still reloads.
- Retire never touches rdy_cnt. An in-order pipeline guarantees the youngest write retires last.
- Register 0: writes and retirements to it are ignored; reads of it never stall.
- Flush: suppresses accept only. Previously accepted entries are unaffected (they are already past ID).
- busy is a registered OR of all out_cnt!=0, updated on the same edge as the counters.
- Latency:
  - An accepted load with LOAD_LAT=1 stalls a dependent instruction in the immediately following cycle for exactly 1 cycle.
  - An ALU producer never stalls a consumer.
- Stall is independent of regwrite_wb in the same cycle: a same-cycle retirement is visible only from the next cycle.

Optional Feature:
- Macro SB_PERF_CNT_EN.
- Defined: adds output stall_cycles (32 bits).
  - Reset 0 on rst.
  - Increments on every cycle where stall=1; wraps modulo 2^32.
  - Adds output load_stall_cycles (32 bits), incremented only when the stall is caused by src_hit.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared pipeline package:
  - REG_ADDR_W=5, NREG constant.
  - reg_addr_t typedef.
  - LOAD_LAT default.
- Sub-module sb_entry (one per register, generated for r=1..NREG-1):
  - Holds out_cnt and rdy_cnt.
  - Inputs: set, set_load, clr.
  - Outputs: pending, not_ready, full.
- Top level: source-compare muxes, stall/accept logic, busy/sb_err registers, optional perf counters.

Test Plan:
- Reset mid-operation: issue load to r5, assert rst for 1 cycle -> out_cnt all 0, busy=0, next add reading r5 -> stall=0.
- Load-use: load r3 accepted at cycle t; cycle t+1 add rs=r3 -> stall=1; cycle t+2 -> stall=0, accept.
- ALU chain: add r4 then sub rs=r4 back-to-back -> stall=0 both cycles; busy=1 until r4 retires twice, then 0.
- WAW and saturation: three loads/adds to r7 (CNT_W=2) without retirement; 4th write to r7 -> stall=1 until regwrite_wb with dest_wb=7, then accepted.
- Simultaneous accept+retire: out_cnt[r9]=1, accept write r9 and retire r9 in one cycle -> out_cnt[r9]=1 and busy stays 1. Separately, retire r12 with count 0 -> sb_err=1 and sticky.
- Flush, r0, and perf counter: load r2 accepted, then add rs=r2 with flush=1 -> stall=0, nothing accepted. Write to r0 -> no tracking. With SB_PERF_CNT_EN defined, the load-use case -> stall_cycles=1 and load_stall_cycles=1.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and types for the issue-side hazard scoreboard.
package hazard_scoreboard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam int LOAD_LAT   = 1;
    localparam int CNT_W      = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: per-register outstanding-write counter and forwardability countdown.
module hazard_scoreboard_sb_entry #(
    parameter int CNT_W    = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic set_load,
    input  logic clr,
    output logic pending,
    output logic pending_nxt,
    output logic not_ready,
    output logic full
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       LOAD_RDY = 2'(LOAD_LAT);

    logic [CNT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] w_out_nxt;
    logic [1:0]       r_rdy_cnt;
    logic [1:0]       w_rdy_nxt;
    logic             w_clr_eff;

    // A retirement against an empty counter is dropped here; the top flags it.
    assign w_clr_eff = clr && (r_out_cnt != '0);

    always_comb begin
        w_out_nxt = r_out_cnt;
        if (set && !w_clr_eff) begin
            w_out_nxt = r_out_cnt + CNT_ONE;
        end else if (!set && w_clr_eff) begin
            w_out_nxt = r_out_cnt - CNT_ONE;
        end
    end

    always_comb begin
        w_rdy_nxt = r_rdy_cnt;
        if (set) begin
            w_rdy_nxt = set_load ? LOAD_RDY : 2'd0;
        end else if (r_rdy_cnt != 2'd0) begin
            w_rdy_nxt = r_rdy_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
            r_rdy_cnt <= 2'd0;
        end else begin
            r_out_cnt <= w_out_nxt;
            r_rdy_cnt <= w_rdy_nxt;
        end
    end

    assign pending     = (r_out_cnt != '0);
    assign pending_nxt = (w_out_nxt != '0);
    assign not_ready   = (r_rdy_cnt != 2'd0);
    assign full        = (r_out_cnt == CNT_MAX);
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writes and stalls on load-use or counter overflow.
// Optional macro SB_PERF_CNT_EN adds stall_cycles / load_stall_cycles performance counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG_P     = NREG,
    parameter int LOAD_LAT_P = LOAD_LAT,
    parameter int CNT_W_P    = CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_regwrite,
    input  logic        issue_is_load,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        flush,
    input  logic        regwrite_wb,
    input  logic [4:0]  dest_wb,
    output logic        stall,
    output logic        busy,
`ifdef SB_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] load_stall_cycles,
`endif
    output logic        sb_err
);
    logic [NREG_P-1:0] w_pending;
    logic [NREG_P-1:0] w_not_ready;
    logic [NREG_P-1:0] w_full;
    logic [NREG_P-1:1] w_pending_nxt;
    logic [NREG_P-1:1] w_set;
    logic [NREG_P-1:1] w_clr;

    logic w_hit_rs, w_hit_rt, w_hit_full, w_src_hit;
    logic w_stall, w_accept, w_retire;
    logic r_busy, r_sb_err;

    // Register 0 is never tracked: its status bits are constant zero.
    assign w_pending[0]   = 1'b0;
    assign w_not_ready[0] = 1'b0;
    assign w_full[0]      = 1'b0;

    assign w_hit_rs   = (rs_id != '0) && w_pending[rs_id] && w_not_ready[rs_id];
    assign w_hit_rt   = (rt_id != '0) && w_pending[rt_id] && w_not_ready[rt_id];
    assign w_hit_full = issue_regwrite && (issue_dest != '0) && w_full[issue_dest];
    assign w_src_hit  = w_hit_rs || w_hit_rt;

    assign w_stall  = !rst && issue_valid && !flush && (w_src_hit || w_hit_full);
    assign w_accept = issue_valid && !flush && !w_stall && issue_regwrite && (issue_dest != '0);
    assign w_retire = regwrite_wb && (dest_wb != '0);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 1; r < NREG_P; r++) begin
            w_set[r] = w_accept && (issue_dest == REG_ADDR_W'(r));
            w_clr[r] = w_retire && (dest_wb == REG_ADDR_W'(r));
        end
    end

    for (genvar r = 1; r < NREG_P; r++) begin : g_entry
        hazard_scoreboard_sb_entry #(
            .CNT_W    (CNT_W_P),
            .LOAD_LAT (LOAD_LAT_P)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .set         (w_set[r]),
            .set_load    (issue_is_load),
            .clr         (w_clr[r]),
            .pending     (w_pending[r]),
            .pending_nxt (w_pending_nxt[r]),
            .not_ready   (w_not_ready[r]),
            .full        (w_full[r])
        );
    end

    // busy tracks the counters as they will be after this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy   <= |w_pending_nxt;
            r_sb_err <= r_sb_err || (w_retire && !w_pending[dest_wb]);
        end
    end

`ifdef SB_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_load_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles      <= 32'd0;
            r_load_stall_cycles <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_stall && w_src_hit) begin
                r_load_stall_cycles <= r_load_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles      = r_stall_cycles;
    assign load_stall_cycles = r_load_stall_cycles;
`endif

    assign stall  = w_stall;
    assign busy   = r_busy;
    assign sb_err = r_sb_err;
endmodule
